// File: rtl/grayscale_frame_sequencer.sv
// Walks a 24-bit BMP pixel array in a byte-wide frame buffer and presents one
// RGB triple per pixel (B,G,R fetch order), with row padding to 4-byte strides.
module grayscale_frame_sequencer #(
  parameter int AW = 20,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [DW-1:0] width_i,
  input  logic [DW-1:0] height_i,
  output logic          mem_rd_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [7:0]    mem_data_i,
  input  logic          pix_ready_i,
  output logic [7:0]    red_o,
  output logic [7:0]    green_o,
  output logic [7:0]    blue_o,
  output logic          pix_valid_o,
  output logic          sof_o,
  output logic          eol_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_RD2, S_CAP, S_OUT} state_t;

  state_t        r_state, w_next;
  logic [DW-1:0] r_width, r_height, r_col, r_row;
  logic [AW-1:0] r_stride, r_row_base, r_mem_addr;
  logic [7:0]    r_red, r_green, r_blue;
  logic          r_busy, r_done;

  logic          w_zero, w_last_col, w_last_row, w_frame_end;
  logic [AW-1:0] w_stride;

  assign w_zero      = (width_i == '0) || (height_i == '0);
  assign w_last_col  = (r_col == r_width - DW'(1));
  assign w_last_row  = (r_row == r_height - DW'(1));
  assign w_frame_end = (r_state == S_OUT) && pix_ready_i && w_last_col && w_last_row;
  // 3*width rounded up to a multiple of 4 bytes
  assign w_stride    = (AW'({width_i, 1'b0}) + AW'(width_i) + AW'(3)) & ~AW'(3);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i && !w_zero) w_next = S_RD0;
      S_RD0:   w_next = S_RD1;
      S_RD1:   w_next = S_RD2;
      S_RD2:   w_next = S_CAP;
      S_CAP:   w_next = S_OUT;
      S_OUT:   if (pix_ready_i) w_next = w_frame_end ? S_IDLE : S_RD0;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_width    <= '0;
      r_height   <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_stride   <= '0;
      r_row_base <= '0;
      r_mem_addr <= '0;
      r_red      <= '0;
      r_green    <= '0;
      r_blue     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_width    <= width_i;
          r_height   <= height_i;
          r_stride   <= w_stride;
          r_row_base <= base_addr_i;
          r_col      <= '0;
          r_row      <= '0;
          if (w_zero) begin
            r_done <= 1'b1;
          end else begin
            r_busy     <= 1'b1;
            r_mem_addr <= base_addr_i;
          end
        end
        S_RD0: r_mem_addr <= r_mem_addr + AW'(1);
        S_RD1: begin
          r_mem_addr <= r_mem_addr + AW'(1);
          r_blue     <= mem_data_i;
        end
        S_RD2: r_green <= mem_data_i;
        S_CAP: r_red   <= mem_data_i;
        // Address register sits on the R byte here, so +1 is the next pixel's B
        S_OUT: if (pix_ready_i) begin
          if (w_last_col) begin
            r_col <= '0;
            if (w_last_row) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_row      <= r_row + DW'(1);
              r_row_base <= r_row_base + r_stride;
              r_mem_addr <= r_row_base + r_stride;
            end
          end else begin
            r_col      <= r_col + DW'(1);
            r_mem_addr <= r_mem_addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_rd_o     = (r_state == S_RD0) || (r_state == S_RD1) || (r_state == S_RD2);
  assign mem_addr_o   = r_mem_addr;
  assign pix_valid_o  = (r_state == S_OUT);
  assign sof_o        = pix_valid_o && (r_row == '0) && (r_col == '0);
  assign eol_o        = pix_valid_o && w_last_col;
  assign red_o        = r_red;
  assign green_o      = r_green;
  assign blue_o       = r_blue;
  assign busy_o       = r_busy;
  assign frame_done_o = r_done;

endmodule

// File: tb/tb_grayscale_frame_sequencer.sv
// Bench for grayscale_frame_sequencer: frame-level model of reads and pixels,
// a per-cycle compare process, and directed frames.
module tb_grayscale_frame_sequencer;
  localparam int AW = 20;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst, start_i, pix_ready_i;
  logic [AW-1:0] base_addr_i, mem_addr_o;
  logic [DW-1:0] width_i, height_i;
  logic          mem_rd_o, pix_valid_o, sof_o, eol_o, busy_o, frame_done_o;
  logic [7:0]    mem_data_i, red_o, green_o, blue_o;

  grayscale_frame_sequencer #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .width_i(width_i), .height_i(height_i), .mem_rd_o(mem_rd_o),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i), .pix_ready_i(pix_ready_i),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o), .pix_valid_o(pix_valid_o),
    .sof_o(sof_o), .eol_o(eol_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] + 8'd100;
  endfunction

  // Frame buffer: data valid exactly one cycle after the read strobe
  always @(posedge clk) mem_data_i <= mem_rd_o ? mem_byte(mem_addr_o) : 8'hEE;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic note_fail(input string nm, input logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got %0h expected nothing (t=%0t)", nm, act, $time);
  endtask

  logic [AW-1:0] exp_rd[$];
  logic [25:0]   exp_px[$];

  task automatic build(input logic [AW-1:0] base, input int w, input int h);
    logic [AW-1:0] stride, a;
    stride = AW'(((3 * w + 3) / 4) * 4);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        a = base + stride * AW'(r) + AW'(3 * c);
        exp_rd.push_back(a);
        exp_rd.push_back(a + AW'(1));
        exp_rd.push_back(a + AW'(2));
        exp_px.push_back({mem_byte(a + AW'(2)), mem_byte(a + AW'(1)), mem_byte(a),
                          (r == 0 && c == 0), (c == w - 1)});
      end
  endtask

  int rd_cnt = 0, hs_cnt = 0, done_cnt = 0, vrun = 0;
  int prev_hs = -1, last_ev_cyc = -10;
  bit spacing_on = 1'b0, busy_seen = 1'b0;
  bit rd_seen [256];
  int run_len [16];

  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_during_valid", {31'd0, mem_rd_o & pix_valid_o}, 0);
      if (busy_o) busy_seen = 1'b1;
      if (mem_rd_o) begin
        rd_cnt++;
        rd_seen[mem_addr_o[7:0]] = 1'b1;
        if (exp_rd.size() == 0) note_fail("rd_extra", mem_addr_o);
        else chk("rd_addr", mem_addr_o, exp_rd.pop_front());
      end
      if (pix_valid_o) begin
        vrun++;
        if (exp_px.size() == 0) note_fail("px_extra", {red_o, green_o, blue_o});
        else chk("pixel", {red_o, green_o, blue_o, sof_o, eol_o}, exp_px[0]);
        if (pix_ready_i) begin
          if (exp_px.size() != 0) void'(exp_px.pop_front());
          if (hs_cnt < 16) run_len[hs_cnt] = vrun;
          vrun = 0;
          if (spacing_on && prev_hs >= 0) chk("spacing", cyc - prev_hs, 5);
          prev_hs = cyc;
          last_ev_cyc = cyc;
          hs_cnt++;
        end
      end else begin
        chk("marks_idle", {30'd0, sof_o, eol_o}, 0);
      end
      if (frame_done_o) begin
        done_cnt++;
        chk("done_busy", {31'd0, busy_o}, 0);
        chk("done_time", cyc, last_ev_cyc + 1);
        chk("done_left", exp_rd.size() + exp_px.size(), 0);
      end
    end
  end

  task automatic start_frame(input logic [AW-1:0] b, input int w, input int h);
    base_addr_i = b;
    width_i     = DW'(w);
    height_i    = DW'(h);
    start_i     = 1'b1;
    if (w == 0 || h == 0) last_ev_cyc = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == d0) note_fail("done_timeout", n);
  endtask

  task automatic wait_neg_rd_after(input int hs);
    int n;
    n = 0;
    @(negedge clk);
    while (!(hs_cnt == hs && mem_rd_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) note_fail("wait_rd_timeout", hs_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, d;
    rst = 1'b1; start_i = 1'b0; pix_ready_i = 1'b1;
    base_addr_i = '0; width_i = '0; height_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {26'd0, mem_rd_o, pix_valid_o, sof_o, eol_o, busy_o, frame_done_o}, 0);
    chk("rst_rgb", {red_o, green_o, blue_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 4x2 frame at BMP offset 54, ready always high
    spacing_on = 1'b1; rd_cnt = 0; hs_cnt = 0; prev_hs = -1;
    build(54, 4, 2);
    chk("model_nrd", exp_rd.size(), 24);
    chk("model_lastrd", exp_rd[23], 77);
    chk("model_px0", exp_px[0], {8'd156, 8'd155, 8'd154, 1'b1, 1'b0});
    chk("model_px3", exp_px[3], {8'd165, 8'd164, 8'd163, 1'b0, 1'b1});
    start_frame(54, 4, 2);
    wait_done(200);
    chk("t1_reads", rd_cnt, 24);
    chk("t1_pixels", hs_cnt, 8);

    // 2x3 frame at 0: stride 8, padding bytes skipped
    for (int i = 0; i < 256; i++) rd_seen[i] = 1'b0;
    rd_cnt = 0; hs_cnt = 0; prev_hs = -1;
    build(0, 2, 3);
    chk("model_row1", exp_rd[6], 8);
    chk("model_row2", exp_rd[12], 16);
    start_frame(0, 2, 3);
    wait_done(200);
    chk("t2_pad6", {31'd0, rd_seen[6]}, 0);
    chk("t2_pad7", {31'd0, rd_seen[7]}, 0);
    chk("t2_pad14", {31'd0, rd_seen[14]}, 0);
    chk("t2_pad15", {31'd0, rd_seen[15]}, 0);
    chk("t2_row1", {31'd0, rd_seen[8]}, 1);
    chk("t2_row2", {31'd0, rd_seen[16]}, 1);
    chk("t2_reads", rd_cnt, 18);
    chk("t2_pixels", hs_cnt, 6);

    // Downstream stall of 3 cycles on pixel 1
    spacing_on = 1'b0; hs_cnt = 0;
    build(300, 3, 1);
    start_frame(300, 3, 1);
    wait_neg_rd_after(1);
    pix_ready_i = 1'b0;
    n = 0;
    while (!pix_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    pix_ready_i = 1'b1;
    wait_done(200);
    chk("stall_run0", run_len[0], 1);
    chk("stall_run1", run_len[1], 4);
    chk("stall_run2", run_len[2], 1);
    chk("stall_pixels", hs_cnt, 3);

    // Zero-sized frames
    rd_cnt = 0; busy_seen = 1'b0;
    start_frame(500, 0, 3);
    wait_done(10);
    start_frame(500, 3, 0);
    wait_done(10);
    repeat (3) @(posedge clk); #1;
    chk("zero_reads", rd_cnt, 0);
    chk("zero_busy", {31'd0, busy_seen}, 0);

    // start_i mid-frame must be ignored
    hs_cnt = 0; d = done_cnt; spacing_on = 1'b1; prev_hs = -1;
    build(100, 3, 2);
    start_frame(100, 3, 2);
    wait_neg_rd_after(2);
    @(posedge clk); #1;
    start_frame(0, 5, 5);
    wait_done(200);
    repeat (20) @(posedge clk); #1;
    chk("mid_pixels", hs_cnt, 6);
    chk("mid_done_cnt", done_cnt, d + 1);
    chk("mid_busy", {31'd0, busy_o}, 0);
    spacing_on = 1'b0;

    // Reset during pixel 3's RD1, then a clean frame
    hs_cnt = 0;
    build(200, 4, 2);
    start_frame(200, 4, 2);
    wait_neg_rd_after(3);
    @(posedge clk); #1;
    rst = 1'b1;
    d = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd.delete();
    exp_px.delete();
    @(negedge clk);
    chk("rr_ctrl", {26'd0, mem_rd_o, pix_valid_o, sof_o, eol_o, busy_o, frame_done_o}, 0);
    chk("rr_rgb", {red_o, green_o, blue_o}, 0);
    repeat (20) @(posedge clk); #1;
    chk("rr_nodone", done_cnt, d);
    chk("rr_busy", {31'd0, busy_o}, 0);
    rd_cnt = 0; hs_cnt = 0; spacing_on = 1'b1; prev_hs = -1;
    build(200, 4, 2);
    start_frame(200, 4, 2);
    wait_done(200);
    chk("rr_reads", rd_cnt, 24);
    chk("rr_pixels", hs_cnt, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
